// File: rtl/enemy_control.sv
// enemy_control: sequences enemy init/move/draw phases per frame, one enemy drawing at a time.
module enemy_control #(
  parameter int N_ENEMY = 4,
  parameter int MOVE_DIV = 2,
  parameter int CHECK_CYCLES = 2,
  parameter int DRAW_TIMEOUT = 512
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_restart,
  input  logic               i_frame_tick,
  input  logic               i_bg_done,
  input  logic [N_ENEMY-1:0] i_draw_done,
  output logic               o_init,
  output logic               o_idle,
  output logic               o_gen_move,
  output logic               o_apply_move,
  output logic               o_bg_draw,
  output logic [N_ENEMY-1:0] o_draw,
  output logic               o_frame_done,
  output logic               o_overrun,
  output logic               o_timeout
);
  localparam int IW = N_ENEMY > 1 ? $clog2(N_ENEMY) : 1;
  localparam int WW = $clog2(DRAW_TIMEOUT) + 1;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_GEN, S_CHECK, S_APPLY, S_BG, S_DRAW, S_GAP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx, w_idx;
  logic [3:0] r_frame_cnt, w_frame_cnt;
  logic [WW-1:0] r_wd;
  logic r_pend, w_pend, r_overrun, r_timeout, w_tmo, w_wd_exp, w_last, w_start;
  assign w_wd_exp = r_wd == WW'(DRAW_TIMEOUT - 1);
  assign w_last = r_idx == IW'(N_ENEMY - 1);
  assign w_start = (i_frame_tick || r_pend) && i_run;
  always_comb begin
    w_next = r_state;
    w_idx = r_idx;
    w_frame_cnt = r_frame_cnt;
    w_pend = r_pend || (i_frame_tick && r_state != S_IDLE);
    w_tmo = 1'b0;
    case (r_state)
      S_INIT: w_next = S_IDLE;
      S_IDLE:
        if (i_restart) begin
          w_next = S_INIT;
          w_frame_cnt = '0;
        end else if (w_start) begin
          w_next = r_frame_cnt == 4'd0 ? S_GEN : S_BG;
          w_frame_cnt = r_frame_cnt == 4'(MOVE_DIV - 1) ? 4'd0 : r_frame_cnt + 4'd1;
          w_pend = 1'b0;
        end
      S_GEN: w_next = S_CHECK;
      S_CHECK: w_next = r_wd == WW'(CHECK_CYCLES - 1) ? S_APPLY : S_CHECK;
      S_APPLY: w_next = S_BG;
      S_BG:
        if (i_bg_done || w_wd_exp) begin
          w_next = S_DRAW;
          w_idx = '0;
          w_tmo = !i_bg_done;
        end
      S_DRAW:
        if (i_draw_done[r_idx] || w_wd_exp) begin
          w_next = S_GAP;
          w_tmo = !i_draw_done[r_idx];
        end
      S_GAP: begin
        w_next = w_last ? S_IDLE : S_DRAW;
        w_idx = w_last ? r_idx : r_idx + IW'(1);
      end
      default: w_next = S_INIT;
    endcase
  end
  // r_wd restarts on every state change: it times CHECK and guards BG/DRAW waits
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_INIT;
      r_idx <= '0;
      r_frame_cnt <= '0;
      r_pend <= 1'b0;
      r_wd <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx;
      r_frame_cnt <= w_frame_cnt;
      r_pend <= w_pend;
      r_wd <= w_next != r_state ? '0 : r_wd + WW'(1);
      r_overrun <= r_overrun || (i_frame_tick && r_state != S_IDLE);
      r_timeout <= r_timeout || w_tmo;
    end
  end
  assign o_init = r_state == S_INIT;
  assign o_idle = r_state inside {S_IDLE, S_CHECK, S_GAP};
  assign o_gen_move = r_state == S_GEN;
  assign o_apply_move = r_state == S_APPLY;
  assign o_bg_draw = r_state == S_BG;
  assign o_draw = r_state == S_DRAW ? N_ENEMY'(1) << r_idx : '0;
  assign o_frame_done = r_state == S_GAP && w_last;
  assign o_overrun = r_overrun;
  assign o_timeout = r_timeout;
endmodule

// File: tb/tb_enemy_control.sv
// tb_enemy_control: vector table, directed frame scenarios and random traffic against a frame-trace model.
module tb_enemy_control;
  localparam int N = 4, MD = 2, CC = 2, TMO = 512;
  localparam logic [9:0] W_INIT = 10'h200, W_IDLE = 10'h100, W_GEN = 10'h080;
  localparam logic [9:0] W_APP = 10'h040, W_BG = 10'h020, W_FD = 10'h101;
  logic clk = 1'b0, i_reset = 1'b1, i_run = 1'b0, i_restart = 1'b0, i_frame_tick = 1'b0, i_bg_done = 1'b0;
  logic [N-1:0] i_draw_done = '0;
  logic o_init, o_idle, o_gen_move, o_apply_move, o_bg_draw, o_frame_done, o_overrun, o_timeout;
  logic [N-1:0] o_draw;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [10:0] q[$];
  logic m_pend, m_ovr, m_tmo, dir;
  int m_fcnt, lat_bg, bcnt, dcnt, dir_bg;
  int lat[N];
  int dir_lat[N];
  typedef struct {logic rst, run, rs, tk, bg; logic [3:0] dd; logic [9:0] ex; logic ov;} vec_t;
  vec_t tv[24];

  enemy_control dut (
    .i_clock(clk), .i_reset(i_reset), .i_run(i_run), .i_restart(i_restart),
    .i_frame_tick(i_frame_tick), .i_bg_done(i_bg_done), .i_draw_done(i_draw_done),
    .o_init(o_init), .o_idle(o_idle), .o_gen_move(o_gen_move), .o_apply_move(o_apply_move),
    .o_bg_draw(o_bg_draw), .o_draw(o_draw), .o_frame_done(o_frame_done),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {o_init, o_idle, o_gen_move, o_apply_move, o_bg_draw, o_draw, o_frame_done};
  endfunction
  function automatic logic [9:0] w_draw(input int i);
    return {5'b0, 4'(1 << i), 1'b0};
  endfunction
  function automatic vec_t v(input logic rst, run, rs, tk, bg, input logic [3:0] dd, input logic [9:0] ex, input logic ov);
    return '{rst, run, rs, tk, bg, dd, ex, ov};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic seg(input logic [9:0] w, input int l);
    int n = l < TMO ? l + 1 : TMO;
    for (int k = 0; k < n; k++) q.push_back({k == n - 1 && l >= TMO, w});
  endtask

  // A launched frame is expanded up front into its whole expected output trace.
  task automatic launch();
    logic move = m_fcnt == 0;
    m_fcnt = (m_fcnt + 1) % MD;
    if (dir) begin
      lat_bg = dir_bg;
      lat = dir_lat;
    end else begin
      lat_bg = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) lat[i] = $urandom_range(0, 5);
      if ($urandom_range(0, 29) == 0) lat[$urandom_range(0, N - 1)] = 600;
    end
    if (move) begin
      q.push_back({1'b0, W_GEN});
      repeat (CC) q.push_back({1'b0, W_IDLE});
      q.push_back({1'b0, W_APP});
    end
    seg(W_BG, lat_bg);
    for (int i = 0; i < N; i++) begin
      seg(w_draw(i), lat[i]);
      q.push_back({1'b0, i == N - 1 ? W_FD : W_IDLE});
    end
  endtask

  task automatic step(input logic run, input logic rs, input logic tk, input logic nz);
    logic [10:0] ex, w;
    logic [3:0] noise, dd;
    int ai = 0;
    @(posedge clk); #1;
    ex = q.size() != 0 ? q[0] : {1'b0, W_IDLE};
    chk("cycle", {outs(), o_overrun, o_timeout}, {ex[9:0], m_ovr, m_tmo});
    i_run = run;
    i_restart = rs;
    i_frame_tick = tk;
    i_bg_done = o_bg_draw ? bcnt == lat_bg : nz && $urandom_range(0, 1) == 1;
    bcnt = o_bg_draw ? bcnt + 1 : 0;
    noise = nz ? 4'($urandom) : 4'd0;
    for (int i = 0; i < N; i++) if (o_draw[i]) ai = i;
    dd = noise & ~o_draw;
    if (o_draw != 0) begin
      if (dcnt == lat[ai]) dd = dd | o_draw;
      dcnt++;
    end else dcnt = 0;
    i_draw_done = dd;
    if (q.size() != 0) begin
      w = q.pop_front();
      if (tk) begin
        m_pend = 1'b1;
        m_ovr = 1'b1;
      end
      if (w[10]) m_tmo = 1'b1;
    end else if (rs) begin
      q.push_back({1'b0, W_INIT});
      m_fcnt = 0;
    end else if ((tk || m_pend) && run) begin
      m_pend = 1'b0;
      launch();
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    {i_run, i_restart, i_frame_tick, i_bg_done, i_draw_done} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {outs(), o_overrun, o_timeout}, {W_INIT, 2'b00});
    i_reset = 1'b0;
    q.delete();
    {m_pend, m_ovr, m_tmo} = '0;
    m_fcnt = 0;
    bcnt = 0;
    dcnt = 0;
  endtask

  task automatic run_frame(input logic inj, input int drop_at, output logic [15:0] order, output int d1);
    logic r = 1'b1, injd = 1'b0, done = 1'b0, tk;
    logic [3:0] last = '0;
    order = '0;
    d1 = 0;
    for (int k = 0; k < 4000 && !done; k++) begin
      tk = inj && !injd && o_draw == 4'b0100;
      if (tk) injd = 1'b1;
      if (k == drop_at) r = 1'b0;
      step(r, 1'b0, tk, 1'b1);
      if (o_draw != last && o_draw != 0) order = {order[11:0], o_draw};
      last = o_draw;
      d1 += int'(o_draw == 4'b0010);
      done = o_frame_done;
    end
    if (!done) chk("frame_bound", 0, 1);
  endtask

  initial begin
    logic [15:0] order;
    int d1, busy, ninit;
    tv[0] = v(1, 0, 0, 0, 0, 4'b0000, W_INIT, 0);
    tv[1] = v(1, 0, 0, 0, 0, 4'b0000, W_INIT, 0);
    tv[2] = v(0, 1, 0, 0, 0, 4'b0000, W_INIT, 0);
    tv[3] = v(0, 1, 0, 1, 0, 4'b0000, W_IDLE, 0);
    tv[4] = v(0, 1, 1, 0, 0, 4'b0000, W_GEN, 0);
    tv[5] = v(0, 1, 0, 0, 0, 4'b0000, W_IDLE, 0);
    tv[6] = v(0, 1, 0, 0, 0, 4'b0000, W_IDLE, 0);
    tv[7] = v(0, 1, 0, 0, 0, 4'b0000, W_APP, 0);
    tv[8] = v(0, 1, 0, 0, 1, 4'b0000, W_BG, 0);
    tv[9] = v(0, 1, 0, 0, 0, 4'b0001, w_draw(0), 0);
    tv[10] = v(0, 1, 0, 0, 1, 4'b0001, W_IDLE, 0);
    tv[11] = v(0, 1, 0, 0, 0, 4'b1101, w_draw(1), 0);
    tv[12] = v(0, 1, 0, 0, 0, 4'b0010, w_draw(1), 0);
    tv[13] = v(0, 1, 0, 0, 0, 4'b0000, W_IDLE, 0);
    tv[14] = v(0, 1, 0, 0, 0, 4'b0100, w_draw(2), 0);
    tv[15] = v(0, 1, 0, 0, 0, 4'b0000, W_IDLE, 0);
    tv[16] = v(0, 1, 0, 0, 0, 4'b1000, w_draw(3), 0);
    tv[17] = v(0, 1, 0, 1, 0, 4'b0000, W_FD, 0);
    tv[18] = v(0, 1, 0, 0, 0, 4'b0000, W_IDLE, 1);
    tv[19] = v(1, 1, 0, 0, 0, 4'b0000, W_BG, 1);
    tv[20] = v(0, 1, 0, 0, 0, 4'b0000, W_INIT, 0);
    tv[21] = v(0, 1, 0, 1, 0, 4'b0000, W_IDLE, 0);
    tv[22] = v(0, 0, 0, 0, 0, 4'b0000, W_GEN, 0);
    tv[23] = v(0, 0, 0, 0, 0, 4'b0000, W_IDLE, 0);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {outs(), o_overrun, o_timeout}, {tv[i].ex, tv[i].ov, 1'b0});
      {i_reset, i_run, i_restart, i_frame_tick, i_bg_done, i_draw_done} =
        {tv[i].rst, tv[i].run, tv[i].rs, tv[i].tk, tv[i].bg, tv[i].dd};
    end
    dir = 1'b1;
    do_reset();
    dir_bg = 2;
    dir_lat = '{256, 256, 256, 256};
    step(1, 0, 1, 0);
    run_frame(1'b1, -1, order, d1);
    chk("slow_order", order, 16'h1248);
    chk("slow_len1", d1, 257);
    chk("slow_ovr", o_overrun, 1);
    step(1, 0, 0, 1);
    chk("pend_idle", o_idle, 1);
    step(1, 0, 0, 1);
    chk("pend_bg", o_bg_draw, 1);
    run_frame(1'b0, -1, order, d1);
    do_reset();
    dir_bg = 1;
    dir_lat = '{3, 600, 3, 3};
    step(1, 0, 1, 1);
    run_frame(1'b0, -1, order, d1);
    chk("to_len1", d1, TMO);
    chk("to_order", order, 16'h1248);
    chk("to_flag", o_timeout, 1);
    chk("to_ovr", o_overrun, 0);
    do_reset();
    dir_bg = 2;
    dir_lat = '{2, 2, 2, 2};
    step(1, 0, 1, 1);
    run_frame(1'b0, 8, order, d1);
    chk("stop_order", order, 16'h1248);
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, k % 10 == 0, 1);
      busy += int'(!o_idle);
    end
    chk("stop_hold", busy, 0);
    step(0, 1, 0, 1);
    ninit = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1);
      ninit += int'(o_init);
    end
    chk("restart_init", ninit, 1);
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    chk("restart_gen", o_gen_move, 1);
    dir = 1'b0;
    do_reset();
    for (int k = 0; k < 6000 && n_fail <= 30; k++)
      step($urandom_range(0, 15) != 0, $urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/enemy_control.md
# enemy_control

Sequencing controller that drives the state-signal side of the enemy datapath blocks: it issues `init`, `idle`, `gen_move`, `apply_move` and a one-hot per-enemy `draw`, and consumes each enemy's `draw_done` and the background redraw handshake. Sits between the frame-rate tick generator and up to `N_ENEMY` enemy instances, whose sprite pixels share one VGA write port. It guarantees that exactly one enemy draws at a time and that movement happens once every `MOVE_DIV` frames.

## Interface
- `N_ENEMY`, 4: number of enemy instances, 1..8.
- `MOVE_DIV`, 2: frames per movement step, 1..15.
- `CHECK_CYCLES`, 2: cycles allowed for collision detection between `gen_move` and `apply_move`, 1..7.
- `DRAW_TIMEOUT`, 512: maximum cycles in any draw wait before it is abandoned.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; game active. Low holds the block in IDLE.
- `restart` in 1: pulse; re-initialise enemies. Sampled in IDLE only.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `bg_done` in 1: background redraw complete.
- `draw_done` in N_ENEMY: per-enemy draw complete.
- `init` out 1: enemy initialise.
- `idle` out 1: enemies idle.
- `gen_move` out 1: choose direction.
- `apply_move` out 1: commit move.
- `bg_draw` out 1: background redraw request.
- `draw` out N_ENEMY: one-hot draw enable.
- `frame_done` out 1: one-cycle pulse at end of frame sequence.
- `overrun` out 1: sticky; a `frame_tick` arrived while busy.
- `timeout` out 1: sticky; a draw wait expired.

## Operation
- All state-signal outputs are Moore decodes of the state register. At most one of `init`, `idle`, `gen_move`, `apply_move`, `bg_draw`, `draw` is nonzero in any cycle.
- States:
  - INIT: `init`=1; goes to IDLE next cycle.
  - IDLE: `idle`=1. On `restart`, goes to INIT. Otherwise, on (`frame_tick` or `pend`) with `run`=1: if `frame_cnt`==0, goes to GEN, else to BG. `pend` clears on that transition.
  - GEN: `gen_move`=1 for 1 cycle, then CHECK.
  - CHECK: `idle`=1 for `CHECK_CYCLES` cycles, then APPLY.
  - APPLY: `apply_move`=1 for 1 cycle, then BG.
  - BG: `bg_draw`=1 until `bg_done`, then DRAW with `idx`=0.
  - DRAW: `draw[idx]`=1 until `draw_done[idx]`, then GAP.
  - GAP: `idle`=1 for 1 cycle; `draw` is low so the enemy clears its `draw_done`. If `idx`==N_ENEMY-1, goes to IDLE and pulses `frame_done`; else `idx`+1, then DRAW.
- `frame_cnt` increments modulo `MOVE_DIV` on each IDLE exit. With `MOVE_DIV`=1, every frame moves.
- A `frame_tick` seen outside IDLE sets `pend` and `overrun`. Multiple ticks collapse into one pending tick.
- `run` falling mid-sequence does not abort; the frame completes, then the block holds in IDLE. `pend` is retained.
- `restart` outside IDLE is ignored.
- Watchdog: `wd` counter reloads on entry to BG or DRAW and counts while in them. At `DRAW_TIMEOUT`-1, the block sets `timeout` and leaves as if done (BG→DRAW, DRAW→GAP).
- `draw_done` bits other than `draw_done[idx]`, and `bg_done` outside BG, are ignored.

## Timing
- Reset: state=INIT. While `reset`=1: `init`=1, all other outputs 0, `idx`=0, `frame_cnt`=0, `pend`=0, `wd`=0. The first cycle after release is also INIT, then IDLE.
- Tick to `gen_move` is 1 cycle: tick sampled in IDLE at cycle t gives GEN at t+1.
- Move frame, GEN through APPLY: 1+`CHECK_CYCLES`+1 cycles. `collision` is valid at APPLY because CHECK ≥ 1.
- Done inputs are sampled registered-free. `draw_done[idx]`=1 at cycle t causes `draw[idx]`=0 at t+1 (GAP).
- Per enemy, draw cost = enemy latency + 1 GAP cycle. `frame_done` is asserted in the GAP cycle whose next state is IDLE.
- `frame_tick` coinciding with the `frame_done` cycle sets `pend` and `overrun`; it is serviced the cycle after IDLE entry.
- `reset` mid-operation returns to INIT within 1 cycle. `overrun` and `timeout` clear only on reset.

## Test plan
- Reset held 3 cycles, then released. Required: `init`=1 through the reset cycles and 1 cycle after, then `idle`=1, `draw`=0, `frame_done`=0.
- `run`=1, `MOVE_DIV`=2, `CHECK_CYCLES`=2, tick at t. Required: `gen_move` at t+1, `idle` at t+2..t+3, `apply_move` at t+4, `bg_draw` at t+5. The next tick skips GEN and raises `bg_draw` at tick+1.
- Model enemies returning `draw_done` 256 cycles after `draw` rises, `N_ENEMY`=4. Required: `draw` goes 0001, 0010, 0100, 1000, each separated by exactly 1 `idle` cycle. `frame_done` pulses once; `draw` is never two-hot.
- Tick injected during DRAW of enemy 2. Required: `overrun`=1; the next frame starts 1 cycle after IDLE entry without a new tick.
- `draw_done[1]` never returned, `DRAW_TIMEOUT`=512. Required: `draw[1]` drops after 512 cycles, `timeout`=1, and enemies 2–3 are still drawn.
- `run`=0 mid-frame, then `restart` in IDLE. Required: the frame completes, no further frames start, then `init`=1 for 1 cycle and `frame_cnt`=0.
